// File: rtl/key_irq_servicer_if.sv
// Bus and stream bundle for key_irq_servicer.
// master: the servicer side (Avalon-MM initiator, event producer).
// slave:  the surrounding logic (key PIO slave, config source, event consumer).
interface key_irq_servicer_if #(
    parameter int KEY_W = 2
);
    logic             irq_in;
    logic [1:0]       avm_address;
    logic             avm_chipselect;
    logic             avm_write_n;
    logic [31:0]      avm_writedata;
    logic [31:0]      avm_readdata;
    logic [KEY_W-1:0] cfg_mask;
    logic             cfg_mask_wr;
    logic             evt_valid;
    logic             evt_ready;
    logic [KEY_W-1:0] evt_edges;
    logic [KEY_W-1:0] evt_level;
    logic             busy;

    modport master (
        input  irq_in, avm_readdata, cfg_mask, cfg_mask_wr, evt_ready,
        output avm_address, avm_chipselect, avm_write_n, avm_writedata,
               evt_valid, evt_edges, evt_level, busy
    );

    modport slave (
        output irq_in, avm_readdata, cfg_mask, cfg_mask_wr, evt_ready,
        input  avm_address, avm_chipselect, avm_write_n, avm_writedata,
               evt_valid, evt_edges, evt_level, busy
    );
endinterface

// File: rtl/key_irq_servicer.sv
// Hardware servicer for a 2-bit key PIO slave: programs the IRQ mask after
// reset, and on each IRQ reads/clears edge capture, samples key levels and
// hands one event downstream over a valid/ready stream.
// Optional build macro KEY_SVC_LOCKOUT_EN adds a post-event debounce lockout
// (counter + trailing edge-capture clear).
//
// state     | meaning
// ----------+------------------------------------------------------
// INIT_MASK | write MASK_INIT to irq_mask (addr 2)
// INIT_CLR  | write all-ones to edge_capture (addr 3), drop stale edges
// IDLE      | wait for a mask request (priority) or irq_in
// MASK_WR   | write latched mask to addr 2
// RD_EDGE   | read edge_capture (addr 3)
// RD_EDGE_W | read-latency cycle, latch edges
// CLR       | write addr 3 to clear captured edges
// RD_LVL    | read key data (addr 0)
// RD_LVL_W  | read-latency cycle, latch levels, drop spurious IRQ
// EMIT      | present event until accepted
// LOCKOUT   | (optional) ignore irq_in while counter runs down
// LOCK_CLR  | (optional) write addr 3 to discard bounce edges
module key_irq_servicer #(
    parameter int               KEY_W     = 2,
    parameter logic [KEY_W-1:0] MASK_INIT = {KEY_W{1'b1}}
`ifdef KEY_SVC_LOCKOUT_EN
    ,
    parameter int               LOCKOUT_CYCLES = 500000,
    parameter int               LOCK_CNT_W     = 20
`endif
) (
    input logic                clk,
    input logic                reset,
    key_irq_servicer_if.master bus
);

    typedef enum logic [3:0] {
        INIT_MASK,
        INIT_CLR,
        IDLE,
        MASK_WR,
        RD_EDGE,
        RD_EDGE_W,
        CLR,
        RD_LVL,
        RD_LVL_W,
        EMIT
`ifdef KEY_SVC_LOCKOUT_EN
        ,
        LOCKOUT,
        LOCK_CLR
`endif
    } state_t;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    state_t           state_q, state_d;
    logic [1:0]       addr_q;
    logic [KEY_W-1:0] edges_q, level_q;
    logic [KEY_W-1:0] mask_q;
    logic             pend_q;

    logic             acc;
    logic             wr;
    logic [1:0]       acc_addr;
    logic [31:0]      wdata;

`ifdef KEY_SVC_LOCKOUT_EN
    localparam logic [LOCK_CNT_W-1:0] LOCK_LOAD = LOCK_CNT_W'(LOCKOUT_CYCLES - 1);
    logic [LOCK_CNT_W-1:0] lock_cnt_q;
`endif

    // Only the key bits of the slave read data carry information.
    logic unused_rdata_hi;
    assign unused_rdata_hi = ^bus.avm_readdata[31:KEY_W];

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= INIT_MASK;
        else       state_q <= state_d;
    end

    // Next-state and bus access decode (one access per state at most).
    always_comb begin
        state_d  = state_q;
        acc      = 1'b0;
        wr       = 1'b0;
        acc_addr = addr_q;
        wdata    = '0;
        case (state_q)
            INIT_MASK: begin
                acc = 1'b1; wr = 1'b1; acc_addr = ADDR_MASK;
                wdata[KEY_W-1:0] = MASK_INIT;
                state_d = INIT_CLR;
            end
            INIT_CLR: begin
                acc = 1'b1; wr = 1'b1; acc_addr = ADDR_EDGE;
                wdata[KEY_W-1:0] = '1;
                state_d = IDLE;
            end
            IDLE: begin
                if (bus.cfg_mask_wr || pend_q) state_d = MASK_WR;
                else if (bus.irq_in)           state_d = RD_EDGE;
            end
            MASK_WR: begin
                acc = 1'b1; wr = 1'b1; acc_addr = ADDR_MASK;
                wdata[KEY_W-1:0] = mask_q;
                state_d = IDLE;
            end
            RD_EDGE: begin
                acc = 1'b1; acc_addr = ADDR_EDGE;
                state_d = RD_EDGE_W;
            end
            RD_EDGE_W: state_d = CLR;
            CLR: begin
                acc = 1'b1; wr = 1'b1; acc_addr = ADDR_EDGE;
                state_d = RD_LVL;
            end
            RD_LVL: begin
                acc = 1'b1; acc_addr = ADDR_DATA;
                state_d = RD_LVL_W;
            end
            RD_LVL_W: state_d = (edges_q != '0) ? EMIT : IDLE;
            EMIT: begin
`ifdef KEY_SVC_LOCKOUT_EN
                if (bus.evt_ready) state_d = LOCKOUT;
`else
                if (bus.evt_ready) state_d = IDLE;
`endif
            end
`ifdef KEY_SVC_LOCKOUT_EN
            LOCKOUT: begin
                if (lock_cnt_q == '0) state_d = LOCK_CLR;
            end
            LOCK_CLR: begin
                acc = 1'b1; wr = 1'b1; acc_addr = ADDR_EDGE;
                wdata[KEY_W-1:0] = '1;
                state_d = IDLE;
            end
`endif
            default: state_d = INIT_MASK;
        endcase
    end

    // Address holds its last value between accesses.
    always_ff @(posedge clk) begin
        if (reset)    addr_q <= '0;
        else if (acc) addr_q <= acc_addr;
    end

    // Event payload capture from the two read-latency cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            edges_q <= '0;
            level_q <= '0;
        end else begin
            if (state_q == RD_EDGE_W) edges_q <= bus.avm_readdata[KEY_W-1:0];
            if (state_q == RD_LVL_W)  level_q <= bus.avm_readdata[KEY_W-1:0];
        end
    end

    // Mask request latch; a newer pulse overwrites the value, IDLE consumes it.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q <= MASK_INIT;
            pend_q <= 1'b0;
        end else begin
            if (bus.cfg_mask_wr) mask_q <= bus.cfg_mask;
            if (state_q == IDLE && state_d == MASK_WR) pend_q <= 1'b0;
            else if (bus.cfg_mask_wr)                  pend_q <= 1'b1;
        end
    end

`ifdef KEY_SVC_LOCKOUT_EN
    // Lockout down-counter, loaded on the event handshake.
    always_ff @(posedge clk) begin
        if (reset)                                   lock_cnt_q <= '0;
        else if (state_q == EMIT && bus.evt_ready)   lock_cnt_q <= LOCK_LOAD;
        else if (state_q == LOCKOUT && lock_cnt_q != '0) lock_cnt_q <= lock_cnt_q - 1'b1;
    end
`endif

    // Reset masks the access decode so the bus is idle while reset is held,
    // even though the state register already sits in INIT_MASK.
    assign bus.avm_chipselect = acc & ~reset;
    assign bus.avm_write_n    = ~(acc & wr & ~reset);
    assign bus.avm_address    = (acc & ~reset) ? acc_addr : addr_q;
    assign bus.avm_writedata  = (acc & wr & ~reset) ? wdata : '0;
    assign bus.evt_valid      = (state_q == EMIT);
    assign bus.evt_edges      = edges_q;
    assign bus.evt_level      = level_q;
    assign bus.busy           = (state_q != IDLE);

endmodule

// File: tb/tb_key_irq_servicer.sv
// Scoreboard bench for key_irq_servicer with a behavioural key PIO slave.
`timescale 1ns/1ps
module tb_key_irq_servicer;
    localparam int KEY_W = 2;

    typedef struct packed {
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] data;
        logic        dc;
    } bus_op_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    key_irq_servicer_if #(.KEY_W(KEY_W)) bus ();

    key_irq_servicer #(
        .KEY_W(KEY_W),
        .MASK_INIT(2'b11)
`ifdef KEY_SVC_LOCKOUT_EN
        , .LOCKOUT_CYCLES(8), .LOCK_CNT_W(4)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Behavioural key PIO slave.
    logic [1:0]  edge_cap, slv_mask, key_lvl, inj;
    logic        irq_force;
    logic [31:0] rdata;
    always @(posedge clk) begin
        if (reset) begin
            edge_cap <= '0;
            slv_mask <= '0;
            rdata    <= '0;
        end else begin
            if (bus.avm_chipselect && !bus.avm_write_n && bus.avm_address == 2'd3)
                edge_cap <= '0;
            else
                edge_cap <= edge_cap | inj;
            if (bus.avm_chipselect && !bus.avm_write_n && bus.avm_address == 2'd2)
                slv_mask <= bus.avm_writedata[1:0];
            if (bus.avm_chipselect && bus.avm_write_n) begin
                case (bus.avm_address)
                    2'd0:    rdata <= {30'd0, key_lvl};
                    2'd2:    rdata <= {30'd0, slv_mask};
                    2'd3:    rdata <= {30'd0, edge_cap};
                    default: rdata <= '0;
                endcase
            end
        end
    end
    assign bus.irq_in       = (|(edge_cap & slv_mask)) | irq_force;
    assign bus.avm_readdata = rdata;

    int errors = 0;
    int checks = 0;
    bus_op_t          exp_bus[$];
    logic [2*KEY_W-1:0] exp_evt[$];

    task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic exp_wr(input logic [1:0] a, input logic [31:0] d, input logic dc = 1'b0);
        exp_bus.push_back('{wr: 1'b1, addr: a, data: d, dc: dc});
    endtask
    task automatic exp_rd(input logic [1:0] a);
        exp_bus.push_back('{wr: 1'b0, addr: a, data: 32'd0, dc: 1'b1});
    endtask
    task automatic exp_service();
        exp_rd(2'd3);
        exp_wr(2'd3, 32'd0, 1'b1);
        exp_rd(2'd0);
    endtask
    task automatic exp_ev(input logic [1:0] e, input logic [1:0] l);
        exp_evt.push_back({e, l});
    endtask

    function automatic bit cond(input int sel);
        case (sel)
            0:       return bus.evt_valid;
            1:       return !bus.busy;
            2:       return bus.avm_chipselect && bus.avm_write_n && bus.avm_address == 2'd3;
            3:       return bus.avm_chipselect && !bus.avm_write_n && bus.avm_address == 2'd3;
            default: return bus.irq_in;
        endcase
    endfunction

    task automatic wait_cond(input int sel, input int budget, input string name, output int n);
        bit hit;
        hit = 1'b0;
        n = 0;
        while (!hit && n < budget) begin
            if (cond(sel)) hit = 1'b1;
            else begin
                tick(1);
                n++;
            end
        end
        chk_eq({"reach_", name}, 64'(hit), 64'd1);
    endtask

    // Bus monitor: every access is popped against the expected sequence.
    task automatic bus_mon();
        bus_op_t e;
        logic    w;
        forever begin
            @(negedge clk);
            if (!reset && bus.avm_chipselect) begin
                w = ~bus.avm_write_n;
                if (exp_bus.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL bus_extra_op: got wr=%0d addr=%0d data=0x%0h, expected no access",
                             w, bus.avm_address, bus.avm_writedata);
                end else begin
                    e = exp_bus.pop_front();
                    chk_eq("bus_op", {29'd0, w, bus.avm_address, (e.dc ? 32'd0 : bus.avm_writedata)},
                                     {29'd0, e.wr, e.addr, (e.dc ? 32'd0 : e.data)});
                end
            end
        end
    endtask

    // Event monitor: each handshake is popped against the expected event.
    task automatic evt_mon();
        logic [2*KEY_W-1:0] e;
        forever begin
            @(negedge clk);
            if (!reset && bus.evt_valid && bus.evt_ready) begin
                if (exp_evt.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL evt_extra: got edges=%b level=%b, expected no event",
                             bus.evt_edges, bus.evt_level);
                end else begin
                    e = exp_evt.pop_front();
                    chk_eq("evt_data", {60'd0, bus.evt_edges, bus.evt_level}, {60'd0, e});
                end
            end
        end
    endtask

    // Held in reset here; checks reset values then releases and checks INIT.
    task automatic reset_release_check();
        int n;
        chk_eq("rst_bus", {bus.avm_chipselect, bus.avm_write_n, bus.avm_address, bus.avm_writedata},
                          {1'b0, 1'b1, 2'd0, 32'd0});
        chk_eq("rst_evt", {bus.evt_valid, bus.evt_edges, bus.evt_level}, 5'b0_00_00);
        chk_eq("rst_busy", 64'(bus.busy), 64'd1);
        exp_wr(2'd2, 32'h3);
        exp_wr(2'd3, 32'h3);
        reset = 1'b0;
        #1;
        chk_eq("init_cycle1", {bus.avm_chipselect, bus.avm_write_n, bus.avm_address}, 4'b1_0_10);
        tick(1);
        chk_eq("init_cycle2", {bus.avm_chipselect, bus.avm_write_n, bus.avm_address}, 4'b1_0_11);
        tick(1);
        chk_eq("init_idle", 64'(bus.busy), 64'd0);
        wait_cond(1, 5, "init_idle", n);
    endtask

`ifndef KEY_SVC_LOCKOUT_EN
    task automatic default_tests();
        int  n;
        bit  seen;
        // basic event with latency
        key_lvl = 2'b01;
        bus.evt_ready = 1'b1;
        exp_service();
        exp_ev(2'b01, 2'b01);
        inj = 2'b01; tick(1); inj = 2'b00;
        wait_cond(4, 5, "irq_rise", n);
        wait_cond(0, 20, "evt1", n);
        chk_eq("evt_latency", 64'(n), 64'd6);
        tick(1);
        wait_cond(1, 10, "idle1", n);

        // backpressure, with a second edge accumulating meanwhile
        bus.evt_ready = 1'b0;
        key_lvl = 2'b10;
        exp_service();
        exp_ev(2'b10, 2'b10);
        inj = 2'b10; tick(1); inj = 2'b00;
        wait_cond(0, 20, "evt2", n);
        inj = 2'b01; tick(1); inj = 2'b00;
        for (int i = 0; i < 20; i++) begin
            chk_eq("bp_hold", {bus.evt_valid, bus.evt_edges, bus.evt_level}, 5'b1_10_10);
            tick(1);
        end
        key_lvl = 2'b11;
        exp_service();
        exp_ev(2'b01, 2'b11);
        bus.evt_ready = 1'b1;
        tick(1);
        chk_eq("bp_valid_drop", 64'(bus.evt_valid), 64'd0);
        wait_cond(0, 20, "evt3", n);
        tick(1);
        wait_cond(1, 10, "idle3", n);

        // spurious IRQ
        exp_service();
        irq_force = 1'b1; tick(1); irq_force = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus.evt_valid) seen = 1'b1;
            tick(1);
        end
        chk_eq("spurious_no_evt", 64'(seen), 64'd0);
        chk_eq("spurious_idle", 64'(bus.busy), 64'd0);

        // mask request during RD_EDGE_W waits for the event
        key_lvl = 2'b01;
        bus.cfg_mask = 2'b10;
        exp_service();
        exp_ev(2'b01, 2'b01);
        exp_wr(2'd2, 32'h2);
        inj = 2'b01; tick(1); inj = 2'b00;
        wait_cond(2, 10, "rd_edge", n);
        tick(1);
        bus.cfg_mask_wr = 1'b1; tick(1); bus.cfg_mask_wr = 1'b0;
        wait_cond(0, 20, "evt4", n);
        tick(1);
        wait_cond(1, 10, "idle4", n);
        tick(3);
        chk_eq("slave_mask", 64'(slv_mask), 64'h2);

        // mask request and irq in the same IDLE cycle: mask first
        key_lvl = 2'b11;
        bus.cfg_mask = 2'b11;
        exp_wr(2'd2, 32'h3);
        exp_service();
        exp_ev(2'b10, 2'b11);
        inj = 2'b10; tick(1); inj = 2'b00;
        bus.cfg_mask_wr = 1'b1; tick(1); bus.cfg_mask_wr = 1'b0;
        wait_cond(0, 20, "evt5", n);
        tick(1);
        wait_cond(1, 10, "idle5", n);
        tick(3);

        // reset mid-service drops the in-flight access and the pending mask
        key_lvl = 2'b01;
        bus.cfg_mask = 2'b01;
        exp_rd(2'd3);
        exp_wr(2'd3, 32'd0, 1'b1);
        inj = 2'b01; tick(1); inj = 2'b00;
        wait_cond(2, 10, "rd_edge6", n);
        tick(1);
        bus.cfg_mask_wr = 1'b1; tick(1); bus.cfg_mask_wr = 1'b0;
        tick(1);
        reset = 1'b1;
        tick(2);
        reset_release_check();
        tick(6);
    endtask
`else
    task automatic lockout_tests();
        int n;
        int k;
        bit found;
        bit seen;
        // event, bounce edges during lockout, one trailing clear
        key_lvl = 2'b01;
        bus.evt_ready = 1'b1;
        exp_service();
        exp_ev(2'b01, 2'b01);
        exp_wr(2'd3, 32'd0, 1'b1);
        inj = 2'b01; tick(1); inj = 2'b00;
        wait_cond(0, 20, "lk_evt", n);
        k = 0;
        found = 1'b0;
        while (!found && k < 20) begin
            tick(1);
            k++;
            inj = (k == 2 || k == 5) ? 2'b10 : 2'b00;
            if (cond(3)) found = 1'b1;
        end
        inj = 2'b00;
        chk_eq("lockout_clear_seen", 64'(found), 64'd1);
        chk_eq("lockout_len", 64'(k), 64'd9);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (bus.evt_valid) seen = 1'b1;
            tick(1);
        end
        chk_eq("lockout_no_second_evt", 64'(seen), 64'd0);
        chk_eq("lockout_idle", 64'(bus.busy), 64'd0);

        // reset in the middle of lockout reruns INIT
        exp_service();
        exp_ev(2'b01, 2'b01);
        inj = 2'b01; tick(1); inj = 2'b00;
        wait_cond(0, 20, "lk_evt2", n);
        tick(4);
        reset = 1'b1;
        tick(2);
        reset_release_check();
        tick(12);
    endtask
`endif

    initial begin
        int n;
        bus.cfg_mask    = '0;
        bus.cfg_mask_wr = 1'b0;
        bus.evt_ready   = 1'b1;
        key_lvl   = '0;
        inj       = '0;
        irq_force = 1'b0;
        fork
            bus_mon();
            evt_mon();
        join_none
        tick(3);
        reset_release_check();
`ifdef KEY_SVC_LOCKOUT_EN
        lockout_tests();
`else
        default_tests();
`endif
        tick(4);
        chk_eq("bus_queue_drained", 64'(exp_bus.size()), 64'd0);
        chk_eq("evt_queue_drained", 64'(exp_evt.size()), 64'd0);
        wait_cond(1, 10, "final_idle", n);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000 ns");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/key_irq_servicer.md
Name: key_irq_servicer

Overview:
- Avalon-MM initiator that services the 2-bit key PIO slave (edge-capture, IRQ mask and data registers) in hardware, with no CPU involvement.
- Programs the slave's IRQ mask at start-up.
- On IRQ: reads edge capture, clears it, samples key levels, then presents one key event on a valid/ready stream to downstream logic (menu/game FSM).

Parameters:
- KEY_W, 2: key count; width of the slave data, mask and edge registers.
- MASK_INIT, 2'b11: value written to the slave irq_mask after reset.
- LOCKOUT_CYCLES, 500000: debounce lockout length in clk cycles (10 ms at 50 MHz). Used only with KEY_SVC_LOCKOUT_EN.
- LOCK_CNT_W, 20: lockout counter width. Must satisfy 2^LOCK_CNT_W > LOCKOUT_CYCLES.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: synchronous, active-high reset.
- irq_in, input, 1: IRQ from the key PIO slave.
- avm_address, output, 2: slave register select (0 data, 2 irq_mask, 3 edge_capture).
- avm_chipselect, output, 1: slave select.
- avm_write_n, output, 1: active-low write strobe.
- avm_writedata, output, 32: write data; bits above KEY_W are 0.
- avm_readdata, input, 32: slave read data, registered, fixed read latency 1.
- cfg_mask, input, KEY_W: new IRQ mask value.
- cfg_mask_wr, input, 1: one-cycle request to write cfg_mask to the slave.
- evt_valid, output, 1: event available.
- evt_ready, input, 1: downstream accepts the event.
- evt_edges, output, KEY_W: captured edge bits.
- evt_level, output, KEY_W: key levels sampled after the clear.
- busy, output, 1: FSM is not in IDLE.

Behaviour:
- Reset values: avm_chipselect=0, avm_write_n=1, avm_address=0, avm_writedata=0, evt_valid=0, evt_edges=0, evt_level=0, state=INIT_MASK. busy=1 in every state except IDLE.
- Bus rules:
  - Every access is a single cycle; there is no waitrequest.
  - Write: chipselect=1, write_n=0 for exactly one cycle.
  - Read: chipselect=1, write_n=1 in cycle N; avm_readdata is sampled at the end of cycle N+1; the bus is idle in N+1.
  - Outside access cycles: chipselect=0, write_n=1, address holds its last value.
- States:
  - INIT_MASK: write MASK_INIT to address 2. -> INIT_CLR.
  - INIT_CLR: write all-ones to address 3 (clears stale edges). -> IDLE.
  - IDLE:
    - If cfg_mask_wr is high, or a pending mask request is latched -> MASK_WR. A cfg_mask_wr pulse arriving in any other state is latched (value and flag) and serviced on the next IDLE entry; a later pulse overwrites the latched value.
    - Else if irq_in=1 -> RD_EDGE.
    - Mask requests have priority over irq_in.
  - MASK_WR: write the latched mask to address 2. -> IDLE.
  - RD_EDGE: read address 3. -> RD_EDGE_W.
  - RD_EDGE_W: latch avm_readdata[KEY_W-1:0] into evt_edges. -> CLR.
  - CLR: write 0 to address 3 (any write clears all bits). -> RD_LVL.
  - RD_LVL: read address 0. -> RD_LVL_W.
  - RD_LVL_W: latch evt_level.
    - If evt_edges != 0 -> EMIT.
    - If evt_edges == 0 (spurious IRQ) -> IDLE, with no event.
  - EMIT: evt_valid=1; evt_edges and evt_level held stable. On evt_valid && evt_ready, evt_valid drops the next cycle. -> IDLE (or LOCKOUT when the optional feature is built in).
- Latency: irq_in rising in IDLE to evt_valid=1 is 6 cycles (RD_EDGE through RD_LVL_W, then EMIT).
- Known window: an edge captured by the slave during RD_EDGE_W or CLR is erased by the clear and never reported. Accepted loss; verification only checks that no false event is generated.
- Backpressure: while in EMIT, further edges accumulate in the slave and irq_in stays high; they are serviced as the next event once IDLE is re-entered.
- Synchronous reset mid-transaction: outputs return to reset values on the next edge; any in-flight access is abandoned; the INIT sequence reruns; the pending mask request is dropped.

Optional Feature:
- Macro: KEY_SVC_LOCKOUT_EN.
- Defined:
  - After an event handshake, the FSM enters LOCKOUT. A counter loads LOCKOUT_CYCLES-1 and decrements to 0; irq_in is ignored throughout.
  - The state after LOCKOUT writes address 3 (discarding bounce edges), then goes to IDLE.
  - cfg_mask_wr pulses during LOCKOUT are latched as usual.
- Undefined: no counter and no LOCKOUT state; EMIT returns directly to IDLE.

Test Plan:
- Reset release -> cycle 1: write addr 2 data 0x3; cycle 2: write addr 3; then IDLE, busy=0.
- slave edge_capture=2'b01, irq_in=1, level=2'b01, evt_ready=1 -> bus sequence: read 3, idle, write 3, read 0, idle. evt_valid=1 six cycles after irq_in, with evt_edges=01, evt_level=01.
- evt_ready held 0 for 20 cycles -> evt_valid, evt_edges and evt_level stable throughout, no bus activity. evt_ready=1 -> evt_valid=0 next cycle.
- irq_in=1, read returns 0 -> clear and level read occur, no evt_valid, FSM returns to IDLE.
- cfg_mask=2'b10, cfg_mask_wr pulsed during RD_EDGE_W -> event completes first, then write addr 2 data 0x2 on IDLE re-entry. Same cycle as irq_in in IDLE -> mask write first.
- KEY_SVC_LOCKOUT_EN with LOCKOUT_CYCLES=8: bounce edges during lockout -> no second event; one write to addr 3 after 8 cycles; reset asserted mid-lockout -> INIT sequence reruns.
